shift_left_sequential: RTL and testbench

SHIFT_LEFT_SEQUENTIAL -- requirements
Module: shift_left_sequential

---
 rtl/shifter_pkg.sv | 23 ++
 rtl/shift_left_stage.sv | 39 +++
 rtl/shift_left_sequential.sv | 116 +++++++++++
 tb/tb_shift_left_sequential.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/shifter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : shifter_pkg
//  Purpose  : Shared constants and the FSM state type for the sequential
//             shift-left-logical unit and its stage helper.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package shifter_pkg;

  localparam int N          = 32;  // datapath width
  localparam int SHAMT_BITS = 5;   // only shamt[4:0] is meaningful
  localparam int NUM_STAGES = 5;   // one stage per shift-amount bit
  localparam int STAGE_W    = 3;   // stage counter width, holds 0..4

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : shifter_pkg
`default_nettype wire

// File: rtl/shift_left_stage.sv
`default_nettype none
// ============================================================================
//  Module   : shift_left_stage
//  Purpose  : Combinational single stage of a logarithmic left shifter.
//             When enabled, shifts data left by 2^idx, zero-filling from the
//             LSB; otherwise passes data through unchanged.
//  Ports    : data_i  [N-1:0]       operand
//             en_i                  apply this stage
//             idx_i   [IDX_W-1:0]   stage index (0..4 -> shift 1,2,4,8,16)
//             data_o  [N-1:0]       stage result
//  Revision : 1.0 - initial release
// ============================================================================
module shift_left_stage #(
  parameter int N     = 32,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     data_i,
  input  logic             en_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [N-1:0]     data_o
);

  always_comb begin
    data_o = data_i;
    if (en_i) begin
      case (idx_i)
        IDX_W'(0): data_o = data_i << 1;
        IDX_W'(1): data_o = data_i << 2;
        IDX_W'(2): data_o = data_i << 4;
        IDX_W'(3): data_o = data_i << 8;
        IDX_W'(4): data_o = data_i << 16;
        // Indices above 4 never occur; pass through rather than shift.
        default:   data_o = data_i;
      endcase
    end
  end

endmodule : shift_left_stage
`default_nettype wire

// File: rtl/shift_left_sequential.sv
`default_nettype none
// ============================================================================
//  Module   : shift_left_sequential
//  Purpose  : Multi-cycle shift-left-logical unit. A request is accepted in
//             IDLE, then five SHIFT cycles each conditionally apply a shift of
//             2^k (k = 0..4, gated by shamt[k]), and the result is presented
//             in DONE until the consumer takes it. Fixed latency of 5 cycles
//             from accept to out_valid, independent of the shift amount.
//  Ports    : clk        clock, rising edge
//             rst        synchronous active-high reset
//             in_valid   request present
//             in_ready   request can be accepted (IDLE only, low during rst)
//             in  [N-1:0]     operand
//             shamt [N-1:0]   shift amount, only [4:0] used (wraps mod 32)
//             out_valid  result present (DONE only)
//             out_ready  consumer accepts result
//             out [N-1:0]     shifted result, zero in IDLE/SHIFT
//             busy       state is not IDLE
//  Revision : 1.0 - initial release
// ============================================================================
module shift_left_sequential #(
  parameter int N = shifter_pkg::N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in,
  input  logic [N-1:0] shamt,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out,
  output logic         busy
);

  import shifter_pkg::*;

  state_e                  state_q, state_d;
  logic [STAGE_W-1:0]      cnt_q,   cnt_d;
  logic [N-1:0]            work_q,  work_d;
  logic [SHAMT_BITS-1:0]   shamt_q, shamt_d;
  logic [N-1:0]            stage_out;

  // Upper shift-amount bits are architecturally ignored (RV32 SLL semantics).
  logic unused_shamt_hi;
  assign unused_shamt_hi = ^shamt[N-1:SHAMT_BITS];

  // A single stage instance is time-multiplexed over the five SHIFT cycles;
  // the stage counter selects both the shift distance and the shamt bit.
  shift_left_stage #(
    .N     (N),
    .IDX_W (STAGE_W)
  ) u_stage (
    .data_i (work_q),
    .en_i   (shamt_q[cnt_q]),
    .idx_i  (cnt_q),
    .data_o (stage_out)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    shamt_d = shamt_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          work_d  = in;
          shamt_d = shamt[SHAMT_BITS-1:0];
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = stage_out;
        if (cnt_q == STAGE_W'(NUM_STAGES - 1)) begin
          // Last stage: park the counter at 0 so it never exceeds 4.
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + STAGE_W'(1);
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
      shamt_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
      shamt_q <= shamt_d;
    end
  end

  // in_ready is masked by rst so no handshake is advertised during reset.
  assign in_ready  = (state_q == ST_IDLE) && !rst;
  assign out_valid = (state_q == ST_DONE);
  assign out       = out_valid ? work_q : '0;
  assign busy      = (state_q != ST_IDLE);

endmodule : shift_left_sequential
`default_nettype wire

// File: tb/tb_shift_left_sequential.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_left_sequential
//  Purpose  : Self-checking directed bench for shift_left_sequential with a
//             scoreboard queue of expected results.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_left_sequential;

  localparam int N = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in;
  logic [N-1:0] shamt;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out;
  logic         busy;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  logic [N-1:0] exp_q[$];

  shift_left_sequential #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: RV32 SLL, shift amount taken modulo 32.
  function automatic logic [N-1:0] sll(input logic [N-1:0] a, input logic [N-1:0] s);
    logic [4:0] amt;
    amt = s[4:0];
    return a << amt;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_result(input string tag);
    logic [N-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected an entry", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, out, e);
    end
  endtask

  // Issue one request, walk it through the five SHIFT cycles, optionally
  // stall it in DONE for 'hold' cycles, then let it retire to IDLE.
  task automatic run_op(input string tag, input logic [N-1:0] a,
                        input logic [N-1:0] s, input int hold);
    int waited;
    logic [N-1:0] held;
    out_ready = (hold == 0);
    in        = a;
    shamt     = s;
    in_valid  = 1'b1;
    waited    = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_fail++;
      $error("FAIL %s_accept: observed in_ready 0 expected 1 within 20 cycles", tag);
      in_valid = 1'b0;
      return;
    end
    tick();
    in_valid = 1'b0;
    exp_q.push_back(sll(a, s));
    for (int k = 1; k <= 4; k++) begin
      check({tag, "_busy"}, N'(busy), N'(1));
      check({tag, "_vld_lo"}, N'(out_valid), N'(0));
      tick();
    end
    check({tag, "_vld_lo"}, N'(out_valid), N'(0));
    tick();
    check({tag, "_vld_hi"}, N'(out_valid), N'(1));
    held = out;
    check_result({tag, "_out"});
    for (int h = 0; h < hold; h++) begin
      tick();
      check({tag, "_hold_vld"}, N'(out_valid), N'(1));
      check({tag, "_hold_out"}, out, held);
      check({tag, "_hold_rdy"}, N'(in_ready), N'(0));
    end
    out_ready = 1'b1;
    tick();
    check({tag, "_idle_busy"}, N'(busy), N'(0));
    check({tag, "_idle_rdy"}, N'(in_ready), N'(1));
  endtask

  initial begin
    int t0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in        = '0;
    shamt     = '0;
    out_ready = 1'b0;

    // Reset: in_ready held low while rst is high, idle outputs afterwards.
    tick();
    tick();
    check("rst_in_ready_lo", N'(in_ready), N'(0));
    rst = 1'b0;
    #1;
    check("rst_in_ready", N'(in_ready), N'(1));
    check("rst_out_valid", N'(out_valid), N'(0));
    check("rst_out", out, '0);
    check("rst_busy", N'(busy), N'(0));

    run_op("sh31",   32'h0000_0001, 32'd31,          0);
    run_op("sh0",    32'hDEAD_BEEF, 32'd0,           0);
    run_op("sh36",   32'h1234_5678, 32'h0000_0024,   0);
    run_op("stall",  32'h0000_00FF, 32'd8,           3);
    run_op("shmax",  32'hFFFF_FFFF, 32'hFFFF_FFFF,   0);

    // Reset in the third SHIFT cycle aborts the operation silently.
    out_ready = 1'b1;
    in        = 32'hAAAA_5555;
    shamt     = 32'd3;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    tick();
    tick();
    check("abort_busy_pre", N'(busy), N'(1));
    rst = 1'b1;
    #1;
    check("abort_rdy_in_rst", N'(in_ready), N'(0));
    tick();
    rst = 1'b0;
    #1;
    check("abort_out_valid", N'(out_valid), N'(0));
    check("abort_out", out, '0);
    check("abort_in_ready", N'(in_ready), N'(1));
    check("abort_busy", N'(busy), N'(0));
    for (int k = 0; k < 6; k++) begin
      tick();
      check("abort_no_result", N'(out_valid), N'(0));
    end
    run_op("post_rst", 32'h0000_0001, 32'd1, 0);

    // Back-to-back with in_valid held high throughout.
    out_ready = 1'b1;
    in        = 32'h0000_0001;
    shamt     = 32'd4;
    in_valid  = 1'b1;
    tick();
    t0 = cyc;
    exp_q.push_back(sll(32'h0000_0001, 32'd4));
    in = 32'hF000_0000;
    for (int k = 0; k < 5; k++) begin
      check("b2b_a_busy", N'(busy), N'(1));
      tick();
    end
    check("b2b_a_vld", N'(out_valid), N'(1));
    check("b2b_a_rdy_lo", N'(in_ready), N'(0));
    check_result("b2b_a_out");
    tick();
    check("b2b_idle_rdy", N'(in_ready), N'(1));
    tick();
    check("b2b_b_accepted", N'(busy), N'(1));
    check("b2b_period", N'(cyc - t0), N'(7));
    exp_q.push_back(sll(32'hF000_0000, 32'd4));
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("b2b_b_vld_lo", N'(out_valid), N'(0));
    tick();
    check("b2b_b_vld", N'(out_valid), N'(1));
    check_result("b2b_b_out");
    tick();
    check("b2b_end_busy", N'(busy), N'(0));

    check("sb_empty", N'(exp_q.size()), N'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_shift_left_sequential
`default_nettype wire
